// File: rtl/fv_stream_rx_pkg.sv
// rtl/fv_stream_rx_pkg.sv - widths and helpers shared by the feature-vector stream receiver
`include "sys_defs.svh"

package fv_stream_rx_pkg;

    localparam int MAX_FV_NUM = `Max_FV_num;
    localparam int VEC_W      = 8 * MAX_FV_NUM;
    localparam int BEAT_W     = `FV_bandwidth;
    localparam int BEAT_BYTES = BEAT_W / 8;
    localparam int NUM_W      = $clog2(MAX_FV_NUM) + 1;
    localparam int PE_W       = $clog2(`Num_Edge_PE);
    // One spare bit so overlong streams can keep counting past the buffer size.
    localparam int CNT_W      = NUM_W + 1;
    localparam int OFF_W      = CNT_W + 1;
    localparam int IN_W       = 3 + PE_W + BEAT_W;

    // Beats a well-formed stream of num bytes must contain.
    function automatic logic [CNT_W-1:0] beats_needed(input logic [NUM_W-1:0] num);
        return CNT_W'((int'(num) + BEAT_BYTES - 1) / BEAT_BYTES);
    endfunction

endpackage

// File: rtl/fv_pingpong_buf.sv
// rtl/fv_pingpong_buf.sv - two feature-vector buffers with full flags and push/pop selects
`include "sys_defs.svh"

module fv_pingpong_buf
    import fv_stream_rx_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              clr,
    input  logic              wr_en,
    input  logic [OFF_W-1:0]  wr_off,
    input  logic [BEAT_W-1:0] wr_data,
    input  logic              push,
    output logic              wr_full,
    input  logic              rd_ready,
    output logic              rd_valid,
    output logic [VEC_W-1:0]  rd_vec
);

    logic [VEC_W-1:0] buf_q [2];
    logic [1:0]       full_q;
    logic             wsel_q;
    logic             rsel_q;
    logic [VEC_W-1:0] wvec;
    logic             pop;

    assign wr_full  = full_q[wsel_q];
    assign rd_valid = full_q[rsel_q];
    assign rd_vec   = buf_q[rsel_q];
    assign pop      = rd_valid && rd_ready;

    // Next contents of the write buffer: optional clear, then the beat bytes overlaid.
    always_comb begin
        wvec = clr ? '0 : buf_q[wsel_q];
        if (wr_en) begin
            for (int i = 0; i < MAX_FV_NUM; i++) begin
                for (int j = 0; j < BEAT_BYTES; j++) begin
                    if (i == int'(wr_off) + j) begin
                        wvec[8*i +: 8] = wr_data[8*j +: 8];
                    end
                end
            end
        end
    end

    // Buffer storage plus flags; a push and a pop always land on different buffers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            buf_q[0] <= '0;
            buf_q[1] <= '0;
            full_q   <= '0;
            wsel_q   <= 1'b0;
            rsel_q   <= 1'b0;
        end else begin
            if (clr || wr_en) begin
                buf_q[wsel_q] <= wvec;
            end
            if (push) begin
                full_q[wsel_q] <= 1'b1;
                wsel_q         <= ~wsel_q;
            end
            if (pop) begin
                full_q[rsel_q] <= 1'b0;
                rsel_q         <= ~rsel_q;
            end
        end
    end

endmodule

// File: rtl/sys_defs.svh
// rtl/sys_defs.svh - shared system sizing macros and the FV bank to edge PE stream beat
`ifndef SYS_DEFS_SVH
`define SYS_DEFS_SVH

`define Max_FV_num   8
`define FV_bandwidth 16
`define Num_Edge_PE  4

typedef struct packed {
    logic                           valid;
    logic                           sos;
    logic                           eos;
    logic [$clog2(`Num_Edge_PE)-1:0] PE_tag;
    logic [`FV_bandwidth-1:0]       FV_data;
} FV_bank_CNTL2Edge_PE;

`endif

// File: rtl/fv_stream_rx.sv
// rtl/fv_stream_rx.sv - receives tagged two-byte beats and assembles feature vectors
`include "sys_defs.svh"

module fv_stream_rx
    import fv_stream_rx_pkg::*;
#(
    parameter logic [PE_W-1:0] PE_ID = '0
) (
    input  logic                clk,
    input  logic                reset,
    input  FV_bank_CNTL2Edge_PE FV_bank_CNTL2Edge_PE_in,
    input  logic [NUM_W-1:0]    Num_FV,
    input  logic                fv_ready,
    output logic                fv_valid,
    output logic [VEC_W-1:0]    fv_vec,
    output logic                busy,
    output logic                drop_err,
    output logic                len_err
);

    typedef enum logic [1:0] {IDLE, RECV, DISCARD} state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              drop_q, len_q;
    logic              set_drop, set_len;
    logic              accept, do_start, close_req;
    logic [CNT_W-1:0]  close_cnt;
    logic              buf_clr, buf_wr, buf_push, wr_full;
    logic [OFF_W-1:0]  wr_off;
    logic [BEAT_W-1:0] wr_data;

    assign accept   = FV_bank_CNTL2Edge_PE_in.valid && (FV_bank_CNTL2Edge_PE_in.PE_tag == PE_ID);
    assign busy     = (state_q != IDLE);
    assign drop_err = drop_q;
    assign len_err  = len_q;

    // Zero any beat byte that lands at or beyond the vector length.
    always_comb begin
        wr_data = '0;
        for (int j = 0; j < BEAT_BYTES; j++) begin
            if (int'(wr_off) + j < int'(Num_FV)) begin
                wr_data[8*j +: 8] = FV_bank_CNTL2Edge_PE_in.FV_data[8*j +: 8];
            end
        end
    end

    // Next state, beat counter and buffer controls.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        set_drop  = 1'b0;
        set_len   = 1'b0;
        do_start  = 1'b0;
        close_req = 1'b0;
        close_cnt = cnt_q;
        buf_clr   = 1'b0;
        buf_wr    = 1'b0;
        buf_push  = 1'b0;
        wr_off    = '0;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (FV_bank_CNTL2Edge_PE_in.sos) do_start = 1'b1;
                    else                             set_len  = 1'b1;
                end
            end
            RECV: begin
                if (accept) begin
                    if (FV_bank_CNTL2Edge_PE_in.sos) begin
                        // A new stream aborts the partial one and restarts below.
                        set_len  = 1'b1;
                        do_start = 1'b1;
                    end else begin
                        if (int'(cnt_q) * BEAT_BYTES + BEAT_BYTES <= MAX_FV_NUM) begin
                            buf_wr = 1'b1;
                            wr_off = OFF_W'(int'(cnt_q) * BEAT_BYTES);
                        end else begin
                            set_len = 1'b1;
                        end
                        if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
                        if (FV_bank_CNTL2Edge_PE_in.eos) begin
                            close_req = 1'b1;
                            close_cnt = cnt_d;
                            state_d   = IDLE;
                        end
                    end
                end
            end
            DISCARD: begin
                if (accept && FV_bank_CNTL2Edge_PE_in.eos) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (do_start) begin
            if (!wr_full) begin
                buf_clr = 1'b1;
                buf_wr  = 1'b1;
                wr_off  = '0;
                cnt_d   = CNT_W'(1);
                if (FV_bank_CNTL2Edge_PE_in.eos) begin
                    close_req = 1'b1;
                    close_cnt = CNT_W'(1);
                    state_d   = IDLE;
                end else begin
                    state_d = RECV;
                end
            end else begin
                // A single-beat stream is already over, so there is nothing to skip.
                set_drop = 1'b1;
                state_d  = FV_bank_CNTL2Edge_PE_in.eos ? IDLE : DISCARD;
            end
        end

        if (close_req) begin
            if (close_cnt == beats_needed(Num_FV)) buf_push = 1'b1;
            else                                   set_len  = 1'b1;
        end
    end

    // FSM state, beat counter and sticky error flags.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            drop_q  <= 1'b0;
            len_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (set_drop) drop_q <= 1'b1;
            if (set_len)  len_q  <= 1'b1;
        end
    end

    fv_pingpong_buf u_buf (
        .clk      (clk),
        .reset    (reset),
        .clr      (buf_clr),
        .wr_en    (buf_wr),
        .wr_off   (wr_off),
        .wr_data  (wr_data),
        .push     (buf_push),
        .wr_full  (wr_full),
        .rd_ready (fv_ready),
        .rd_valid (fv_valid),
        .rd_vec   (fv_vec)
    );

endmodule

// File: tb/tb_fv_stream_rx.sv
// tb/tb_fv_stream_rx.sv - scoreboard bench for the feature-vector stream receiver
module tb_fv_stream_rx;
    import fv_stream_rx_pkg::*;

    logic             clk;
    logic             reset;
    logic [IN_W-1:0]  in_b;
    logic [NUM_W-1:0] num_fv;
    logic             fv_ready;
    logic             fv_valid;
    logic [VEC_W-1:0] fv_vec;
    logic             busy;
    logic             drop_err;
    logic             len_err;

    int checks = 0;
    int errors = 0;

    logic [VEC_W-1:0] exp_q [$];

    logic             prev_v, prev_r;
    logic [VEC_W-1:0] prev_vec;

    fv_stream_rx #(.PE_ID(2'd2)) dut (
        .clk                     (clk),
        .reset                   (reset),
        .FV_bank_CNTL2Edge_PE_in (in_b),
        .Num_FV                  (num_fv),
        .fv_ready                (fv_ready),
        .fv_valid                (fv_valid),
        .fv_vec                  (fv_vec),
        .busy                    (busy),
        .drop_err                (drop_err),
        .len_err                 (len_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [VEC_W-1:0] act, input logic [VEC_W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // One beat presented for one rising edge; called at posedge+1.
    task automatic beat(input logic s, input logic e, input logic [PE_W-1:0] tag, input logic [15:0] d);
        in_b = {1'b1, s, e, tag, d};
        @(posedge clk);
        #1;
        in_b = '0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 40) begin
            @(posedge clk);
            n++;
        end
        @(posedge clk);
        #1;
        chk("drain", VEC_W'(exp_q.size()), '0);
    endtask

    // Monitor: pop and compare on every handshake, and check hold-while-stalled.
    always @(negedge clk) begin
        if (reset) begin
            prev_v = 1'b0;
        end else begin
            if (prev_v && !prev_r) begin
                chk("hold_valid", VEC_W'(fv_valid), VEC_W'(1));
                chk("hold_vec", fv_vec, prev_vec);
            end
            if (fv_valid && fv_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_vec actual=%h required=none", fv_vec);
                end else begin
                    chk("vec", fv_vec, exp_q.pop_front());
                end
            end
            prev_v   = fv_valid;
            prev_r   = fv_ready;
            prev_vec = fv_vec;
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin
        reset    = 1'b1;
        in_b     = '0;
        num_fv   = NUM_W'(6);
        fv_ready = 1'b1;
        prev_v   = 1'b0;
        prev_r   = 1'b0;
        prev_vec = '0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        chk("rst_valid", VEC_W'(fv_valid), '0);
        chk("rst_busy", VEC_W'(busy), '0);
        chk("rst_drop", VEC_W'(drop_err), '0);
        chk("rst_len", VEC_W'(len_err), '0);
        chk("rst_vec", fv_vec, '0);

        // Basic three-beat stream.
        exp_q.push_back(64'h0000_0605_0403_0201);
        beat(1, 0, 2, 16'h0201);
        chk("busy_recv", VEC_W'(busy), VEC_W'(1));
        beat(0, 0, 2, 16'h0403);
        beat(0, 1, 2, 16'h0605);
        chk("latency_valid", VEC_W'(fv_valid), VEC_W'(1));
        chk("busy_after_eos", VEC_W'(busy), '0);
        drain();

        // Single-beat stream; a beat for another PE is ignored.
        num_fv = NUM_W'(1);
        beat(1, 1, 3, 16'h5555);
        chk("other_tag_valid", VEC_W'(fv_valid), '0);
        chk("other_tag_len", VEC_W'(len_err), '0);
        exp_q.push_back(64'h0000_0000_0000_0011);
        beat(1, 1, 2, 16'hAB11);
        chk("single_valid", VEC_W'(fv_valid), VEC_W'(1));
        drain();

        // Backpressure: two buffered, third dropped, popped in order.
        num_fv   = NUM_W'(6);
        fv_ready = 1'b0;
        exp_q.push_back(64'h0000_1615_1413_1211);
        beat(1, 0, 2, 16'h1211); beat(0, 0, 2, 16'h1413); beat(0, 1, 2, 16'h1615);
        exp_q.push_back(64'h0000_2625_2423_2221);
        beat(1, 0, 2, 16'h2221); beat(0, 0, 2, 16'h2423); beat(0, 1, 2, 16'h2625);
        beat(1, 0, 2, 16'h3231);
        chk("drop_busy", VEC_W'(busy), VEC_W'(1));
        beat(0, 0, 2, 16'h3433); beat(0, 1, 2, 16'h3635);
        chk("drop_err", VEC_W'(drop_err), VEC_W'(1));
        chk("drop_no_len", VEC_W'(len_err), '0);
        chk("drop_valid", VEC_W'(fv_valid), VEC_W'(1));
        fv_ready = 1'b1;
        drain();

        // sos mid-stream aborts and restarts.
        beat(1, 0, 2, 16'h5151); beat(0, 0, 2, 16'h5252);
        chk("pre_abort_len", VEC_W'(len_err), '0);
        exp_q.push_back(64'h0000_6665_6463_6261);
        beat(1, 0, 2, 16'h6261);
        chk("abort_len", VEC_W'(len_err), VEC_W'(1));
        beat(0, 0, 2, 16'h6463); beat(0, 1, 2, 16'h6665);
        drain();

        // Reset on beat 2 of a stream; odd length next.
        num_fv = NUM_W'(5);
        beat(1, 0, 2, 16'h7171);
        in_b  = {1'b1, 1'b0, 1'b0, 2'd2, 16'h7272};
        reset = 1'b1;
        #1;
        chk("mid_rst_valid", VEC_W'(fv_valid), '0);
        chk("mid_rst_busy", VEC_W'(busy), '0);
        chk("mid_rst_drop", VEC_W'(drop_err), '0);
        chk("mid_rst_len", VEC_W'(len_err), '0);
        chk("mid_rst_vec", fv_vec, '0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        in_b  = '0;
        exp_q.push_back(64'h0000_0075_7473_7271);
        beat(1, 0, 2, 16'h7271); beat(0, 0, 2, 16'h7473); beat(0, 1, 2, 16'h7675);
        chk("odd_len_ok", VEC_W'(len_err), '0);
        drain();

        // Short stream: eos on beat 2 of 3.
        num_fv = NUM_W'(6);
        beat(1, 0, 2, 16'h4141); beat(0, 1, 2, 16'h4242);
        chk("short_len", VEC_W'(len_err), VEC_W'(1));
        chk("short_valid", VEC_W'(fv_valid), '0);
        @(posedge clk);
        #1;
        chk("short_valid2", VEC_W'(fv_valid), '0);
        exp_q.push_back(64'h0000_4645_4443_4241);
        beat(1, 0, 2, 16'h4241); beat(0, 0, 2, 16'h4443); beat(0, 1, 2, 16'h4645);
        drain();

        // Pop of one buffer and close of the other on the same edge.
        fv_ready = 1'b0;
        exp_q.push_back(64'h0000_8685_8483_8281);
        beat(1, 0, 2, 16'h8281); beat(0, 0, 2, 16'h8483); beat(0, 1, 2, 16'h8685);
        exp_q.push_back(64'h0000_9695_9493_9291);
        beat(1, 0, 2, 16'h9291); beat(0, 0, 2, 16'h9493);
        fv_ready = 1'b1;
        beat(0, 1, 2, 16'h9695);
        chk("nogap_valid", VEC_W'(fv_valid), VEC_W'(1));
        chk("nogap_vec", fv_vec, 64'h0000_9695_9493_9291);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
